// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity selectors and default frame geometry.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEF_PRESCALE   = 8;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame options in, received byte and status strobes out.
import uart_pkg::*;

// Data_Valid is a one-cycle strobe with no ready/backpressure: the consumer must take
// P_DATA in the strobe cycle. Par_err/Stp_err are one-cycle strobes, never concurrent with Data_Valid.
interface uart_rx_if #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_err;
  logic                  Stp_err;
  logic [2:0]            state;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Par_err, Stp_err, state
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Par_err, Stp_err, state
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-sample majority vote around mid-bit and decision/last-edge flags.
import uart_pkg::*;

module uart_rx_sampler #(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic rxs,
  input  logic restart,
  output logic decide,
  output logic last_edge,
  output logic vote
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] E_LO   = CW'(PRESCALE/2 - 1);
  localparam logic [CW-1:0] E_MID  = CW'(PRESCALE/2);
  localparam logic [CW-1:0] E_HI   = CW'(PRESCALE/2 + 1);
  localparam logic [CW-1:0] E_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] edge_cnt;
  logic          s_lo;
  logic          s_mid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      s_lo     <= 1'b1;
      s_mid    <= 1'b1;
    end else begin
      if (restart || edge_cnt == E_LAST) edge_cnt <= '0;
      else                               edge_cnt <= edge_cnt + 1'b1;
      if (edge_cnt == E_LO)  s_lo  <= rxs;
      if (edge_cnt == E_MID) s_mid <= rxs;
    end
  end

  // The third sample is the live rxs, so the vote is ready in the decision cycle itself.
  assign decide    = (edge_cnt == E_HI);
  assign last_edge = (edge_cnt == E_LAST);
  assign vote      = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, LSB-first shift register, parity/stop checks, registered outputs.
import uart_pkg::*;

module uart_rx #(
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  uart_rx_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic                  rx_meta;
  logic                  rxs;
  logic [2:0]            state;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic                  par_fail;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  decide;
  logic                  last_edge;
  logic                  vote;
  logic                  restart;
  logic                  exp_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rxs     <= rx_meta;
    end
  end

  // Hold the counter at zero while idling so the first low cycle is edge 0, and
  // zero it on every return to IDLE so a back-to-back start bit lines up too.
  assign restart = (state == IDLE && rxs)
                 || (state == START && decide && vote)
                 || (state == STOP && decide);

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rxs       (rxs),
    .restart   (restart),
    .decide    (decide),
    .last_edge (last_edge),
    .vote      (vote)
  );

  assign exp_par = (par_typ_l == PAR_ODD) ? ~(^shreg) : (^shreg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= PAR_EVEN;
      par_fail   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state     <= START;
            par_en_l  <= bus.PAR_EN;
            par_typ_l <= bus.PAR_TYP;
            par_fail  <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        START: begin
          if (decide && vote) state <= IDLE;
          else if (last_edge) state <= DATA;
        end
        DATA: begin
          if (decide) begin
            shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (last_edge && bit_cnt == BW'(DATA_WIDTH))
            state <= par_en_l ? PARITY : STOP;
        end
        PARITY: begin
          if (decide) par_fail <= (vote != exp_par);
          if (last_edge) state <= STOP;
        end
        STOP: begin
          if (decide) begin
            stp_err <= ~vote;
            par_err <= par_fail;
            if (vote && !par_fail) begin
              data_valid <= 1'b1;
              p_data     <= shreg;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA     = p_data;
  assign bus.Data_Valid = data_valid;
  assign bus.Par_err    = par_err;
  assign bus.Stp_err    = stp_err;
  assign bus.state      = state;

endmodule
